da_fir_param: RTL and testbench

DA_FIR_PARAM -- requirements
Module: da_fir_param

---
 rtl/da_fir_param.sv | 194 +++++++++++++++++++
 tb/tb_da_fir_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/da_fir_param.sv
// Distributed-arithmetic FIR dot product: NB banks of K taps, bit-serial over
// XW-bit samples, MSB slice first, three-stage pipeline (LUT, adder tree, acc).
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   start            request one dot product (accepted only in IDLE)
//   signed_mode      1 = two's complement samples, 0 = unsigned (sampled at accept)
//   x_in             packed samples, tap t at [t*XW +: XW]; bank t/K, addr bit t%K
//   coef_we/bank/addr/data  LUT write port (effective only in IDLE)
//   coef_err         1-cycle pulse: LUT write attempted while busy, dropped
//   busy             high in every state except IDLE
//   done             1-cycle pulse, y valid
//   y                signed result, held until next accept
module da_fir_param #(
   parameter int NB = 2,
   parameter int K  = 4,
   parameter int XW = 8,
   parameter int CW = 16,
   localparam int AW = CW + $clog2(NB) + XW,
   localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [NB*K*XW-1:0]   x_in,
   input  logic                 coef_we,
   input  logic [BW-1:0]        coef_bank,
   input  logic [K-1:0]         coef_addr,
   input  logic [CW-1:0]        coef_data,
   output logic                 coef_err,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        y
);

   localparam int SW = CW + $clog2(NB);
   localparam int JW = (XW > 1) ? $clog2(XW) : 1;
   localparam int LD = 2 ** K;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CW-1:0]        lut [NB][LD];

   logic [NB*K*XW-1:0]   x_q;
   logic                 sm_q;
   logic [JW-1:0]        j_q;

   logic [CW-1:0]        s1_word [NB];
   logic                 s1_vld;
   logic                 s1_neg;
   logic                 s1_last;

   logic signed [SW-1:0] s2_sum;
   logic                 s2_vld;
   logic                 s2_neg;
   logic                 s2_last;

   logic signed [AW-1:0] acc;

   logic                 accept;
   logic                 issue;
   logic                 lut_wr;
   logic [K-1:0]         addr [NB];
   logic signed [SW-1:0] sum_c;
   logic signed [AW-1:0] ext;
   logic signed [AW-1:0] addend;
   logic signed [AW-1:0] acc_nxt;

   // A LUT write in the same IDLE cycle as start wins; start is dropped.
   assign lut_wr = (state_q == S_IDLE) && coef_we;
   assign accept = (state_q == S_IDLE) && start && !coef_we;
   assign issue  = (state_q == S_RUN);
   assign busy   = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (j_q == '0) state_d = S_DRAIN;
         S_DRAIN: if (s2_vld && s2_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-bank LUT address: bit j of each of the bank's K samples.
   always_comb begin
      for (int b = 0; b < NB; b++) begin
         addr[b] = '0;
         for (int k = 0; k < K; k++) begin
            addr[b][k] = x_q[(b*K+k)*XW + int'(j_q)];
         end
      end
   end

   // Adder tree over the banks, each word sign-extended to SW bits.
   always_comb begin
      sum_c = '0;
      for (int b = 0; b < NB; b++) begin
         sum_c = sum_c + SW'($signed(s1_word[b]));
      end
   end

   // MSB slice of a signed sample carries weight -2^(XW-1): subtract by
   // inverting the addend and injecting a carry of one.
   always_comb begin
      ext     = AW'(s2_sum);
      addend  = s2_neg ? ~ext : ext;
      acc_nxt = (acc <<< 1) + addend + AW'(s2_neg);
   end

   // Coefficient storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (lut_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (NB == 1 || int'(coef_bank) == b) begin
               lut[b][coef_addr] <= coef_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         sm_q     <= 1'b0;
         j_q      <= '0;
         for (int b = 0; b < NB; b++) begin
            s1_word[b] <= '0;
         end
         s1_vld   <= 1'b0;
         s1_neg   <= 1'b0;
         s1_last  <= 1'b0;
         s2_sum   <= '0;
         s2_vld   <= 1'b0;
         s2_neg   <= 1'b0;
         s2_last  <= 1'b0;
         acc      <= '0;
         y        <= '0;
         done     <= 1'b0;
         coef_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         coef_err <= coef_we && (state_q != S_IDLE);
         done     <= 1'b0;

         if (accept) begin
            x_q  <= x_in;
            sm_q <= signed_mode;
            j_q  <= JW'(XW - 1);
            acc  <= '0;
         end

         if (issue) begin
            if (j_q != '0) begin
               j_q <= j_q - JW'(1);
            end
            for (int b = 0; b < NB; b++) begin
               s1_word[b] <= lut[b][addr[b]];
            end
         end
         s1_vld  <= issue;
         s1_neg  <= issue && sm_q && (j_q == JW'(XW - 1));
         s1_last <= issue && (j_q == '0);

         s2_vld  <= s1_vld;
         s2_neg  <= s1_neg;
         s2_last <= s1_last;
         if (s1_vld) begin
            s2_sum <= sum_c;
         end

         if (s2_vld) begin
            acc <= acc_nxt;
         end

         if (state_q == S_DONE) begin
            y    <= acc;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_da_fir_param.sv
// Scoreboard bench for da_fir_param (NB=2, K=4, XW=8, CW=16).
// Expected results are queued at accept and checked when done pulses.
module tb_da_fir_param;

   localparam int NB = 2;
   localparam int K  = 4;
   localparam int XW = 8;
   localparam int CW = 16;
   localparam int AW = 25;
   localparam int NT = NB * K;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic             signed_mode = 1'b0;
   logic [NT*XW-1:0] x_in = '0;
   logic             coef_we = 1'b0;
   logic [0:0]       coef_bank = '0;
   logic [K-1:0]     coef_addr = '0;
   logic [CW-1:0]    coef_data = '0;
   logic             coef_err;
   logic             busy;
   logic             done;
   logic [AW-1:0]    y;

   da_fir_param #(.NB(NB), .K(K), .XW(XW), .CW(CW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .signed_mode (signed_mode),
      .x_in        (x_in),
      .coef_we     (coef_we),
      .coef_bank   (coef_bank),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_err    (coef_err),
      .busy        (busy),
      .done        (done),
      .y           (y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint y;
      int     t;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [CW-1:0] mlut [NB][2**K];
   int            n_vec = 0;
   int            n_bad = 0;
   int            n_done = 0;
   int            n_push = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint model(input logic [NT*XW-1:0] x, input logic sm);
      longint s = 0;
      for (int j = 0; j < XW; j++) begin
         longint p = 0;
         longint w = longint'(1) << j;
         for (int b = 0; b < NB; b++) begin
            logic [K-1:0] a = '0;
            for (int k = 0; k < K; k++) a[k] = x[(b*K+k)*XW + j];
            p += longint'($signed(mlut[b][a]));
         end
         if (sm && j == XW - 1) w = -w;
         s += w * p;
      end
      return s;
   endfunction

   always @(negedge clk) begin
      if (resetn && done) begin
         n_done++;
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("y", longint'($signed(y)), mon_e.y);
            chk("latency", cyc, mon_e.t);
         end
      end
   end

   task automatic write_lut(input int b, input int a, input logic [CW-1:0] d);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_bank = 1'(b);
      coef_addr = K'(a);
      coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
      mlut[b][a] = d;
   endtask

   task automatic launch(input logic [NT*XW-1:0] x, input logic sm,
                         input longint exp, input bit track);
      @(negedge clk);
      start       = 1'b1;
      x_in        = x;
      signed_mode = sm;
      @(posedge clk);
      #1;
      if (track) begin
         sb.push_back('{exp, cyc + XW + 3});
         n_push++;
      end
      start = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL timeout: got %0d results pending, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NT*XW-1:0] xr;
      longint           er;
      int               t0;
      int               d0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_coef_err", coef_err, 0);
      chk("rst_y", y, 0);
      resetn = 1'b1;

      for (int b = 0; b < NB; b++)
         for (int a = 0; a < 2**K; a++)
            write_lut(b, a, CW'($countones(a)));

      launch({NT{8'd3}}, 1'b0, 24, 1);
      drain();
      launch({NT{8'hFF}}, 1'b1, -8, 1);
      drain();
      launch({NT{8'hFF}}, 1'b0, 2040, 1);
      drain();

      write_lut(0, 1, 16'h7FFF);
      launch(64'h80, 1'b1, -4194176, 1);
      drain();
      repeat (3) @(negedge clk);
      chk("y_held", longint'($signed(y)), -4194176);
      write_lut(0, 1, 16'd1);

      // LUT write and start while running
      xr = {$urandom, $urandom};
      d0 = n_done;
      launch(xr, 1'b0, model(xr, 1'b0), 1);
      repeat (3) @(negedge clk);
      coef_we   = 1'b1;
      coef_bank = 1'b1;
      coef_addr = 4'd5;
      coef_data = 16'h1234;
      start     = 1'b1;
      x_in      = '1;
      @(negedge clk);
      chk("coef_err_pulse", coef_err, 1);
      coef_we = 1'b0;
      start   = 1'b0;
      @(negedge clk);
      chk("coef_err_clear", coef_err, 0);
      drain();
      repeat (15) @(negedge clk);
      chk("one_done", n_done - d0, 1);
      chk("busy_idle", busy, 0);
      // taps 4 and 6 all ones: bank 1 address 5 at every slice
      launch({8'h00, 8'hFF, 8'h00, 8'hFF, 32'h0}, 1'b0, 510, 1);
      drain();

      // reset mid-run
      d0 = n_done;
      launch({NT{8'd3}}, 1'b0, 0, 0);
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_y", y, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_no_done", n_done - d0, 0);
      launch({NT{8'd3}}, 1'b0, 24, 1);
      drain();

      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 3; w++)
            write_lut($urandom_range(0, NB - 1), $urandom_range(0, 15),
                      CW'($urandom));
         xr = {$urandom, $urandom};
         er = model(xr, 1'(i));
         launch(xr, 1'(i), er, 1);
         drain();
      end

      // start held high: accepts at t0 and t0+12
      xr = {$urandom, $urandom};
      er = model(xr, 1'b1);
      @(negedge clk);
      start       = 1'b1;
      x_in        = xr;
      signed_mode = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      sb.push_back('{er, t0 + 11});
      sb.push_back('{er, t0 + 23});
      n_push += 2;
      while (cyc < t0 + 12) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      drain();
      repeat (15) @(negedge clk);
      chk("total_done", n_done, n_push);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
